// File: rtl/prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_scan
// Purpose  : Sequencer in front of the PRM obstacle checker. It takes one
//            15-bit configuration code per beat (one sample point along a
//            roadmap edge), registers it onto the checker inputs, and folds
//            the checker's combinational edge_mask into a per-edge verdict.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : sample stream handshake
//   in_code         : configuration code (bit 14 = O ... bit 0 = A)
//   in_edge         : edge id, captured on the first beat of an edge
//   in_last         : final sample of the edge
//   chk_code        : registered code driven to the checker
//   chk_mask        : checker collision result for chk_code
//   out_valid/ready : verdict handshake
//   out_edge        : edge id of the verdict
//   out_blocked     : any checked sample collided
//   out_first_hit   : index of first colliding sample (0 when clear)
//   out_count       : number of samples accepted, saturating
//   out_sat         : sample count saturated
// ============================================================================
module prm_edge_scan #(
  parameter int EDGE_W      = 16,
  parameter int CNT_W       = 8,
  parameter int EARLY_ABORT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       in_code,
  input  logic [EDGE_W-1:0] in_edge,
  input  logic              in_last,
  output logic [14:0]       chk_code,
  input  logic              chk_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EDGE_W-1:0] out_edge,
  output logic              out_blocked,
  output logic [CNT_W-1:0]  out_first_hit,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             ABORT_EN = (EARLY_ABORT != 0);

  state_t              state_q, state_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                blocked_q, blocked_d;
  logic [CNT_W-1:0]    first_hit_q, first_hit_d;
  logic [14:0]         chk_code_q, chk_code_d;
  logic                chk_vld_q, chk_vld_d;
  logic [CNT_W-1:0]    chk_idx_q, chk_idx_d;   // index of the code on chk_code
  logic                out_valid_q, out_valid_d;

  logic                w_beat;
  logic                w_hit;
  logic                w_blk;
  logic [CNT_W-1:0]    w_idx_inc;
  logic [CNT_W-1:0]    w_cnt_inc;

  assign in_ready = ~rst & ((state_q == IDLE) | (state_q == SCAN) | (state_q == DRAIN));
  assign w_beat   = in_valid & in_ready;
  // The checker is combinational, so its answer for chk_code is valid now.
  assign w_hit    = chk_vld_q & chk_mask;
  // Blocked including a hit that is only being registered this cycle, so the
  // sample arriving alongside the first hit is already drained.
  assign w_blk    = blocked_q | w_hit;
  assign w_idx_inc = (idx_q == CNT_MAX) ? CNT_MAX : idx_q + CNT_W'(1);
  assign w_cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    blocked_d   = blocked_q;
    first_hit_d = first_hit_q;
    chk_code_d  = chk_code_q;
    chk_vld_d   = chk_vld_q;
    chk_idx_d   = chk_idx_q;
    out_valid_d = out_valid_q;

    if (w_hit && !blocked_q) begin
      blocked_d   = 1'b1;
      first_hit_d = chk_idx_q;
    end

    case (state_q)
      IDLE: begin
        chk_vld_d = 1'b0;
        if (w_beat) begin
          edge_d      = in_edge;
          idx_d       = '0;
          cnt_d       = CNT_W'(1);
          sat_d       = 1'b0;
          blocked_d   = 1'b0;
          first_hit_d = '0;
          chk_code_d  = in_code;
          chk_vld_d   = 1'b1;
          chk_idx_d   = '0;
          state_d     = in_last ? WAIT : SCAN;
        end
      end
      SCAN: begin
        chk_vld_d = 1'b0;
        if (ABORT_EN && w_blk) begin
          state_d = DRAIN;
        end
        if (w_beat) begin
          idx_d = w_idx_inc;
          cnt_d = w_cnt_inc;
          sat_d = sat_q | (cnt_q == CNT_MAX);
          if (!(ABORT_EN && w_blk)) begin
            chk_code_d = in_code;
            chk_vld_d  = 1'b1;
            chk_idx_d  = w_idx_inc;
          end
          if (in_last) begin
            state_d = WAIT;
          end
        end
      end
      DRAIN: begin
        chk_vld_d = 1'b0;
        if (w_beat) begin
          idx_d = w_idx_inc;
          cnt_d = w_cnt_inc;
          sat_d = sat_q | (cnt_q == CNT_MAX);
          if (in_last) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        chk_vld_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        chk_vld_d = 1'b0;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        chk_vld_d   = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      blocked_q   <= 1'b0;
      first_hit_q <= '0;
      chk_code_q  <= '0;
      chk_vld_q   <= 1'b0;
      chk_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      blocked_q   <= blocked_d;
      first_hit_q <= first_hit_d;
      chk_code_q  <= chk_code_d;
      chk_vld_q   <= chk_vld_d;
      chk_idx_q   <= chk_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign chk_code      = chk_code_q;
  assign out_valid     = out_valid_q;
  assign out_edge      = edge_q;
  assign out_blocked   = blocked_q;
  assign out_first_hit = first_hit_q;
  assign out_count     = cnt_q;
  assign out_sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_prm_edge_scan
// Purpose  : Directed self-checking bench for prm_edge_scan. Two instances
//            share the sample stream: u_a (CNT_W=4, early abort) and
//            u_b (CNT_W=8, no early abort). Each has a small checker model
//            flagging up to two colliding codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prm_edge_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [14:0] in_code = '0;
  logic [15:0] in_edge = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        hit_en = 1'b0;
  logic [14:0] hit0 = 15'h7FFF;
  logic [14:0] hit1 = 15'h7FFF;

  logic        in_ready_a, out_valid_a, out_blocked_a, out_sat_a, mask_a;
  logic [14:0] chk_code_a;
  logic [15:0] out_edge_a;
  logic [3:0]  out_first_hit_a, out_count_a;

  logic        in_ready_b, out_valid_b, out_blocked_b, out_sat_b, mask_b;
  logic [14:0] chk_code_b;
  logic [15:0] out_edge_b;
  logic [7:0]  out_first_hit_b, out_count_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mask_a = hit_en & ((chk_code_a == hit0) | (chk_code_a == hit1));
  assign mask_b = hit_en & ((chk_code_b == hit0) | (chk_code_b == hit1));

  prm_edge_scan #(.EDGE_W(16), .CNT_W(4), .EARLY_ABORT(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_code(in_code), .in_edge(in_edge), .in_last(in_last),
    .chk_code(chk_code_a), .chk_mask(mask_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_edge(out_edge_a),
    .out_blocked(out_blocked_a), .out_first_hit(out_first_hit_a),
    .out_count(out_count_a), .out_sat(out_sat_a)
  );

  prm_edge_scan #(.EDGE_W(16), .CNT_W(8), .EARLY_ABORT(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_code(in_code), .in_edge(in_edge), .in_last(in_last),
    .chk_code(chk_code_b), .chk_mask(mask_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_edge(out_edge_b),
    .out_blocked(out_blocked_b), .out_first_hit(out_first_hit_b),
    .out_count(out_count_b), .out_sat(out_sat_b)
  );

  // One beat presented for exactly one cycle; returns 1 ns after the edge.
  task automatic beat(input logic [14:0] code, input logic [15:0] eid, input logic last);
    in_valid = 1'b1; in_code = code; in_edge = eid; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready_a !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready_a); else n_pass++;
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid_a); else n_pass++;
    n_checks++; if (chk_code_a !== 15'h0) $display("FAIL rst_chk_code got %h want 0", chk_code_a); else n_pass++;
    n_checks++; if ({out_edge_a, out_count_a, out_first_hit_a, out_blocked_a, out_sat_a} !== '0)
      $display("FAIL rst_outs got %h/%0d/%0d/%b/%b want all 0", out_edge_a, out_count_a, out_first_hit_a, out_blocked_a, out_sat_a); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready_a !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready_a); else n_pass++;
  endtask

  task automatic test_clean_edge();
    hit_en = 1'b0;
    for (int i = 0; i < 5; i++) beat(15'h0011 + 15'(i), 16'h0012, i == 4);
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL clean_early_valid got %b want 0", out_valid_a); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid_a !== 1'b1) $display("FAIL clean_valid got %b want 1", out_valid_a); else n_pass++;
    n_checks++; if (out_edge_a !== 16'h0012) $display("FAIL clean_edge got %h want 0012", out_edge_a); else n_pass++;
    n_checks++; if (out_blocked_a !== 1'b0 || out_first_hit_a !== 4'd0)
      $display("FAIL clean_blocked got %b/%0d want 0/0", out_blocked_a, out_first_hit_a); else n_pass++;
    n_checks++; if (out_count_a !== 4'd5 || out_sat_a !== 1'b0)
      $display("FAIL clean_count got %0d sat %b want 5 sat 0", out_count_a, out_sat_a); else n_pass++;
    release_result();
    n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
      $display("FAIL clean_release got valid %b ready %b want 0 1", out_valid_a, in_ready_a); else n_pass++;
  endtask

  task automatic test_hit_sample3();
    logic [14:0] codes [6];
    codes = '{15'h0101, 15'h0202, 15'h0303, 15'h4A5F, 15'h0505, 15'h0606};
    hit_en = 1'b1; hit0 = 15'h4A5F; hit1 = 15'h7FFF;
    for (int i = 0; i < 4; i++) beat(codes[i], 16'h0034, 1'b0);
    beat(codes[4], 16'h0034, 1'b0);
    n_checks++; if (chk_code_a !== 15'h4A5F) $display("FAIL hit_freeze4 got %h want 4a5f", chk_code_a); else n_pass++;
    beat(codes[5], 16'h0034, 1'b1);
    n_checks++; if (chk_code_a !== 15'h4A5F) $display("FAIL hit_freeze5 got %h want 4a5f", chk_code_a); else n_pass++;
    n_checks++; if (chk_code_b !== 15'h0606) $display("FAIL hit_noabort_code got %h want 0606", chk_code_b); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid_a !== 1'b1 || out_blocked_a !== 1'b1)
      $display("FAIL hit_blocked got valid %b blocked %b want 1 1", out_valid_a, out_blocked_a); else n_pass++;
    n_checks++; if (out_first_hit_a !== 4'd3 || out_count_a !== 4'd6)
      $display("FAIL hit_idx got first %0d count %0d want 3 6", out_first_hit_a, out_count_a); else n_pass++;
    n_checks++; if (out_blocked_b !== 1'b1 || out_first_hit_b !== 8'd3 || out_count_b !== 8'd6)
      $display("FAIL hit_b got %b/%0d/%0d want 1/3/6", out_blocked_b, out_first_hit_b, out_count_b); else n_pass++;
    release_result();
  endtask

  task automatic test_backpressure();
    hit_en = 1'b0;
    beat(15'h0A01, 16'h0ABC, 1'b0);
    beat(15'h0A02, 16'h0ABC, 1'b1);
    @(posedge clk); #1;
    // Next edge's single beat waits at the input during the stall.
    in_valid = 1'b1; in_code = 15'h0B01; in_edge = 16'h0BEE; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (out_valid_a !== 1'b1 || out_edge_a !== 16'h0ABC || out_count_a !== 4'd2 || out_blocked_a !== 1'b0)
        $display("FAIL bp_hold cyc %0d got %b/%h/%0d/%b want 1/0abc/2/0", c, out_valid_a, out_edge_a, out_count_a, out_blocked_a); else n_pass++;
      n_checks++; if (in_ready_a !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready_a); else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
      $display("FAIL bp_release got valid %b ready %b want 0 1", out_valid_a, in_ready_a); else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (in_ready_a !== 1'b0) $display("FAIL bp_accept got ready %b want 0", in_ready_a); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid_a !== 1'b1 || out_edge_a !== 16'h0BEE || out_count_a !== 4'd1)
      $display("FAIL bp_next got %b/%h/%0d want 1/0bee/1", out_valid_a, out_edge_a, out_count_a); else n_pass++;
    release_result();
  endtask

  task automatic test_saturation();
    hit_en = 1'b1; hit0 = 15'h1000 + 15'd17; hit1 = 15'h7FFF;
    for (int i = 0; i < 20; i++) beat(15'h1000 + 15'(i), 16'h0055, i == 19);
    @(posedge clk); #1;
    n_checks++; if (out_count_a !== 4'd15 || out_sat_a !== 1'b1)
      $display("FAIL sat_count got %0d sat %b want 15 sat 1", out_count_a, out_sat_a); else n_pass++;
    n_checks++; if (out_blocked_a !== 1'b1 || out_first_hit_a !== 4'd15)
      $display("FAIL sat_first_hit got %b/%0d want 1/15", out_blocked_a, out_first_hit_a); else n_pass++;
    n_checks++; if (out_count_b !== 8'd20 || out_sat_b !== 1'b0 || out_first_hit_b !== 8'd17)
      $display("FAIL sat_b got %0d/%b/%0d want 20/0/17", out_count_b, out_sat_b, out_first_hit_b); else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mid_edge();
    hit_en = 1'b0;
    beat(15'h0701, 16'h0077, 1'b0);
    beat(15'h0702, 16'h0077, 1'b0);
    in_valid = 1'b1; in_code = 15'h0703; in_edge = 16'h0077; rst = 1'b1;
    #1;
    n_checks++; if (in_ready_a !== 1'b0) $display("FAIL rmid_in_ready got %b want 0", in_ready_a); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid_a !== 1'b0 || chk_code_a !== 15'h0)
      $display("FAIL rmid_state got valid %b code %h want 0 0", out_valid_a, chk_code_a); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL rmid_no_verdict got %b want 0", out_valid_a); else n_pass++;
    beat(15'h0055, 16'h0078, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (out_valid_a !== 1'b1 || out_count_a !== 4'd1 || out_edge_a !== 16'h0078 || out_blocked_a !== 1'b0)
      $display("FAIL rmid_next got %b/%0d/%h/%b want 1/1/0078/0", out_valid_a, out_count_a, out_edge_a, out_blocked_a); else n_pass++;
    release_result();
  endtask

  task automatic test_single_hit();
    hit_en = 1'b1; hit0 = 15'h2222; hit1 = 15'h7FFF;
    beat(15'h2222, 16'h0099, 1'b1);
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL single_early got %b want 0", out_valid_a); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid_a !== 1'b1 || out_blocked_a !== 1'b1 || out_first_hit_a !== 4'd0 || out_count_a !== 4'd1)
      $display("FAIL single_hit got %b/%b/%0d/%0d want 1/1/0/1", out_valid_a, out_blocked_a, out_first_hit_a, out_count_a); else n_pass++;
    release_result();
  endtask

  task automatic test_back_to_back_hits();
    hit_en = 1'b1; hit0 = 15'h0302; hit1 = 15'h0303;
    for (int i = 0; i < 4; i++) beat(15'h0301 + 15'(i), 16'h00C4, i == 3);
    n_checks++; if (chk_code_a !== 15'h0302 || chk_code_b !== 15'h0304)
      $display("FAIL b2b_codes got %h/%h want 0302/0304", chk_code_a, chk_code_b); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_blocked_a !== 1'b1 || out_first_hit_a !== 4'd1 || out_count_a !== 4'd4)
      $display("FAIL b2b_a got %b/%0d/%0d want 1/1/4", out_blocked_a, out_first_hit_a, out_count_a); else n_pass++;
    n_checks++; if (out_blocked_b !== 1'b1 || out_first_hit_b !== 8'd1 || out_count_b !== 8'd4)
      $display("FAIL b2b_b got %b/%0d/%0d want 1/1/4", out_blocked_b, out_first_hit_b, out_count_b); else n_pass++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_hit_sample3();
    test_backpressure();
    test_saturation();
    test_reset_mid_edge();
    test_single_hit();
    test_back_to_back_hits();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prm_edge_scan.md
Name: prm_edge_scan

Overview:
- Upstream sequencer of the PRM obstacle checker (`prm_oblgc_chk*`). It drives the checker's 15-bit code A..O and consumes its combinational `edge_mask`.
- It takes a stream of 15-bit quantised arm-configuration codes, one sample point along a roadmap edge per beat.
- Each code is presented to the checker and the per-sample mask results are reduced into one per-edge verdict.
- The verdict carries the blocked flag, the first colliding sample index and the sample count, and goes downstream to roadmap pruning.

Parameters:
- EDGE_W, 16, width of the edge identifier.
- CNT_W, 8, width of the sample index and count.
- EARLY_ABORT, 1, when 1, samples after the first hit are drained without being checked.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_code  in  15  configuration code; bit 14 = O ... bit 0 = A.
- in_edge  in  EDGE_W  edge id; sampled only on the first beat of an edge.
- in_last  in  1  final sample of the edge.
- chk_code  out  15  registered code driven to the checker inputs O..A.
- chk_mask  in  1  checker `edge_mask` output; 1 = configuration collides.
- out_valid  out  1  verdict valid.
- out_ready  in  1  downstream accepts the verdict.
- out_edge  out  EDGE_W  edge id of the verdict.
- out_blocked  out  1  1 if any checked sample collided.
- out_first_hit  out  CNT_W  index of the first colliding sample; 0 when not blocked.
- out_count  out  CNT_W  samples accepted, saturating.
- out_sat  out  1  sample count saturated at 2^CNT_W-1.

Behaviour:
- **Reset** (rst=1 at a clk edge, from any state, including mid-edge):
  - state goes to IDLE; the pending edge is discarded with no verdict.
  - out_valid, out_blocked, out_sat = 0; out_edge, out_first_hit, out_count = 0.
  - chk_code = 0; chk_vld (internal) = 0; in_ready = 0 during the reset cycle.
- **Handshake:**
  - A beat transfers when in_valid & in_ready.
  - A result transfers when out_valid & out_ready.
  - out_* are held stable while out_valid=1 and out_ready=0.
- **States:**
  - IDLE:
    - in_ready=1.
    - On a beat: latch in_edge, idx=0, blocked=0, cnt=1, sat=0.
    - Register in_code into chk_code and set chk_vld=1.
    - Go to SCAN, or to WAIT if in_last.
  - SCAN:
    - in_ready=1.
    - Each beat: chk_code<=in_code, chk_vld<=1, idx+=1, cnt+=1 (saturating; sets sat).
    - With no beat: chk_vld<=0.
    - On in_last: go to WAIT, or to DRAIN mid-edge if EARLY_ABORT and blocked.
  - DRAIN (EARLY_ABORT=1 only):
    - Entered on the cycle blocked becomes 1 while the edge is open.
    - in_ready=1; beats are counted but chk_code is not updated and chk_vld<=0.
    - On in_last: go to WAIT.
  - WAIT:
    - in_ready=0.
    - One cycle for the last chk_mask evaluation; then out_valid<=1 and go to DONE.
  - DONE:
    - in_ready=0; out_valid=1.
    - On out_ready: out_valid<=0 and go to IDLE.
- **Mask evaluation:**
  - chk_mask is sampled on the cycle after chk_code updates, only when chk_vld=1.
  - If chk_mask=1 and blocked=0: blocked<=1 and first_hit<=index of that sample.
  - A pipeline register tracks the index of the code currently on chk_code.
- **Latency:**
  - Last beat at cycle t gives out_valid=1 at t+2.
  - First beat of the next edge is accepted at the earliest in the cycle after the result handshake.
- **Saturation:** cnt and idx stop at 2^CNT_W-1 and out_sat=1. first_hit for samples beyond saturation reports 2^CNT_W-1.
- **Single-sample edge** (in_last on the first beat): IDLE goes straight to WAIT; the verdict reflects that one sample.
- **Simultaneous hit and in_last:** the hit is counted; WAIT is entered; DRAIN is skipped.
- **EARLY_ABORT=0:** all samples are checked; first_hit still reports the earliest hit.

Test Plan:
- **Clean edge:** edge 0x0012, 5 codes, all chk_mask=0 → out_valid 2 cycles after the last beat; blocked=0, first_hit=0, count=5.
- **Hit on sample 3:** 6 codes, chk_mask=1 only for the code 0x4A5F (sample idx 3), EARLY_ABORT=1 → blocked=1, first_hit=3, count=6; chk_code frozen at 0x4A5F for samples 4..5.
- **Backpressure:** out_ready held 0 for 10 cycles → out_* stable, in_ready=0 throughout; release → out_valid drops next cycle and the next edge is accepted the cycle after.
- **Saturation:** CNT_W=4, 20 samples → count=15, out_sat=1.
- **Reset mid-edge:** rst asserted at sample 2 → no verdict; out_valid=0, chk_code=0; a following 1-sample edge yields count=1.
- **Single-sample edge with hit:** in_last on the first beat, chk_mask=1 → blocked=1, first_hit=0, count=1, latency 2.
